// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-index and data widths,
// the write-port bundle, the buffered long-result entry and the source select.
package wb_arbiter_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    localparam int NREGS = 1 << REG_W;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  xlen_t;

    // One register-file write: enable, address, data.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        xlen_t    data;
    } wb_port_t;

    // Payload held in the long-result FIFO.
    typedef struct packed {
        reg_idx_t rd;
        xlen_t    data;
    } wb_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_PIPE   = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

    // One-hot mask for a scoreboard update; x0 never produces a bit.
    function automatic logic [NREGS-1:0] reg_onehot(input reg_idx_t r, input logic en);
        reg_onehot = '0;
        if (en && (r != '0)) begin
            reg_onehot[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency units and the writeback arbiter.
// master = the surrounding CPU (drives results and issues), slave = the arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic     pipe_valid;
    reg_idx_t pipe_rd;
    xlen_t    pipe_data;

    logic     lu_valid;
    reg_idx_t lu_rd;
    xlen_t    lu_data;
    logic     lu_ready;

    logic     issue_valid;
    reg_idx_t issue_rd;

    logic [NREGS-1:0] busy_o;
    logic     stall_o;
    logic     err_o;

    logic     write_reg;
    reg_idx_t target_reg;
    xlen_t    write_rd_data;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output lu_valid, lu_rd, lu_data,
        output issue_valid, issue_rd,
        input  lu_ready, busy_o, stall_o, err_o,
        input  write_reg, target_reg, write_rd_data
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lu_valid, lu_rd, lu_data,
        input  issue_valid, issue_rd,
        output lu_ready, busy_o, stall_o, err_o,
        output write_reg, target_reg, write_rd_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO for long-latency results. The head entry
// is visible combinationally so the arbiter can write it the cycle it wins.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    wb_entry_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head    = mem[rd_ptr_reg[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer advance; push and pop may happen together.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage write; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM/WB results and buffered/bypassed long-latency
// results onto the single register-file write port, keeps the busy scoreboard
// and forces a one-cycle pipeline stall when buffered results starve.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t        fifo_head;
    wb_entry_t        push_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             lu_accept;
    logic             stall;
    wb_src_e          src;
    wb_port_t         sel;
    logic             sel_long;

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic [NREGS-1:0] busy_reg, busy_next;
    logic [NREGS-1:0] set_mask, clr_mask;
    logic             err_reg, err_next;
    wb_port_t         port_reg, port_next;

    assign stall      = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    assign lu_accept  = bus.lu_valid && !fifo_full;
    assign push_entry = '{rd: bus.lu_rd, data: bus.lu_data};
    assign fifo_pop   = (src == SRC_FIFO);
    assign fifo_push  = lu_accept && (src != SRC_BYPASS);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Source priority: starved FIFO head, pipeline, FIFO head, lu bypass.
    always_comb begin
        src = SRC_IDLE;
        if (stall && !fifo_empty) begin
            src = SRC_FIFO;
        end else if (bus.pipe_valid) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (lu_accept) begin
            src = SRC_BYPASS;
        end
    end

    // Mux the chosen result; long results also clear their busy bit.
    always_comb begin
        sel      = '0;
        sel_long = 1'b0;
        case (src)
            SRC_PIPE: begin
                sel.valid = 1'b1;
                sel.rd    = bus.pipe_rd;
                sel.data  = bus.pipe_data;
            end
            SRC_FIFO: begin
                sel.valid = 1'b1;
                sel.rd    = fifo_head.rd;
                sel.data  = fifo_head.data;
                sel_long  = 1'b1;
            end
            SRC_BYPASS: begin
                sel.valid = 1'b1;
                sel.rd    = bus.lu_rd;
                sel.data  = bus.lu_data;
                sel_long  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next write-port value; writes to x0 are suppressed.
    always_comb begin
        port_next       = sel;
        port_next.valid = sel.valid && (sel.rd != '0);
    end

    // Starvation counter: counts pipeline wins over a waiting FIFO head.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fifo_pop || fifo_empty) begin
            starve_cnt_next = '0;
        end else if (src == SRC_PIPE) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    // Sticky protocol errors: pipeline result during stall, unexpected lu result.
    always_comb begin
        err_next = err_reg;
        if (bus.pipe_valid && stall) begin
            err_next = 1'b1;
        end
        if (bus.lu_valid && !busy_reg[bus.lu_rd]) begin
            err_next = 1'b1;
        end
    end

    // Scoreboard: per-bit clear then set, so a same-cycle set wins.
    assign set_mask     = reg_onehot(bus.issue_rd, bus.issue_valid);
    assign clr_mask     = reg_onehot(sel.rd, sel_long);
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
            assign busy_next[gi] = set_mask[gi] | (busy_reg[gi] & ~clr_mask[gi]);
        end
    endgenerate

    // State registers for port, scoreboard, counter and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_reg       <= '0;
            busy_reg       <= '0;
            starve_cnt_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            port_reg       <= port_next;
            busy_reg       <= busy_next;
            starve_cnt_reg <= starve_cnt_next;
            err_reg        <= err_next;
        end
    end

    assign bus.lu_ready      = !fifo_full;
    assign bus.busy_o        = busy_reg;
    assign bus.stall_o       = stall;
    assign bus.err_o         = err_reg;
    assign bus.write_reg     = port_reg.valid;
    assign bus.target_reg    = port_reg.rd;
    assign bus.write_rd_data = port_reg.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    wb_arbiter_if bus();

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_busy = '0;
    int          m_cnt  = 0;
    logic        m_err  = 1'b0;
    logic        m_wr   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the arbitration rules once per clock.
    initial begin : model
        int          src;   // 0 idle, 1 pipe, 2 fifo, 3 bypass
        int          nq;
        logic        stl;
        logic        acc;
        logic        v;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] nb;
        ent_t        e;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_busy = '0;
                m_cnt  = 0;
                m_err  = 1'b0;
                m_wr   = 1'b0;
                m_rd   = '0;
                m_data = '0;
            end else begin
                nq  = m_q.size();
                stl = (m_cnt == STARVE_LIMIT);
                if (stl && nq > 0)        src = 2;
                else if (bus.pipe_valid)  src = 1;
                else if (nq > 0)          src = 2;
                else if (bus.lu_valid)    src = 3;
                else                      src = 0;
                acc = bus.lu_valid && (nq < DEPTH);
                if ((bus.pipe_valid && stl) || (bus.lu_valid && !m_busy[bus.lu_rd]))
                    m_err = 1'b1;
                v = 1'b1; rd = '0; data = '0;
                case (src)
                    1: begin rd = bus.pipe_rd;  data = bus.pipe_data;  end
                    2: begin rd = m_q[0].rd;    data = m_q[0].data;    end
                    3: begin rd = bus.lu_rd;    data = bus.lu_data;    end
                    default: v = 1'b0;
                endcase
                nb = m_busy;
                if (src >= 2 && rd != 0) nb[rd] = 1'b0;
                if (bus.issue_valid && bus.issue_rd != 0) nb[bus.issue_rd] = 1'b1;
                m_busy = nb;
                if (src == 2 || nq == 0) m_cnt = 0;
                else if (src == 1)       m_cnt = m_cnt + 1;
                if (src == 2) void'(m_q.pop_front());
                if (acc && src != 3) begin
                    e.rd = bus.lu_rd; e.data = bus.lu_data;
                    m_q.push_back(e);
                end
                m_wr = v && (rd != 0); m_rd = rd; m_data = data;
            end
        end
    end

    // Compare process: every falling edge, DUT against model.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cmp_write_reg", {31'd0, bus.write_reg}, {31'd0, m_wr});
            if (m_wr) begin
                chk("cmp_target_reg", {27'd0, bus.target_reg}, {27'd0, m_rd});
                chk("cmp_write_data", bus.write_rd_data, m_data);
            end
            chk("cmp_busy", bus.busy_o, m_busy);
            chk("cmp_stall", {31'd0, bus.stall_o}, (m_cnt == STARVE_LIMIT) ? 32'd1 : 32'd0);
            chk("cmp_err", {31'd0, bus.err_o}, {31'd0, m_err});
            chk("cmp_lu_ready", {31'd0, bus.lu_ready}, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_all();
        bus.pipe_valid  = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.lu_valid    = 1'b0; bus.lu_rd   = '0; bus.lu_data   = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
    endtask

    task automatic set_pipe(input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid = 1'b1; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = 1'b1; bus.lu_rd = rd; bus.lu_data = d;
    endtask

    task automatic set_issue(input logic [4:0] rd);
        bus.issue_valid = 1'b1; bus.issue_rd = rd;
    endtask

    task automatic chk_port(input string name, input logic [4:0] rd, input logic [31:0] d);
        chk({name, "_wr"}, {31'd0, bus.write_reg}, 32'd1);
        chk({name, "_rd"}, {27'd0, bus.target_reg}, {27'd0, rd});
        chk({name, "_data"}, bus.write_rd_data, d);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin : stim
        clr_all();
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_write_reg", {31'd0, bus.write_reg}, 32'd0);
        chk("rst_target", {27'd0, bus.target_reg}, 32'd0);
        chk("rst_data", bus.write_rd_data, 32'd0);
        chk("rst_busy", bus.busy_o, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_err", {31'd0, bus.err_o}, 32'd0);
        chk("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
        rst = 1'b1;
        tick();
        chk("release_no_write", {31'd0, bus.write_reg}, 32'd0);

        // Pipe only
        set_pipe(5'd5, 32'hDEAD_BEEF); tick(); clr_all();
        chk_port("pipe_only", 5'd5, 32'hDEAD_BEEF);
        chk("pipe_only_busy", bus.busy_o, 32'd0);

        // Bypass with scoreboard
        set_issue(5'd7); tick(); clr_all();
        chk("issue7_busy", bus.busy_o, 32'h0000_0080);
        set_lu(5'd7, 32'h1234); tick(); clr_all();
        chk_port("bypass", 5'd7, 32'h1234);
        chk("bypass_busy_clear", bus.busy_o, 32'd0);

        // Contention, fill and starvation
        set_issue(5'd3); tick();
        set_issue(5'd4); tick();
        set_issue(5'd9); tick(); clr_all();
        chk("cont_busy", bus.busy_o, 32'h0000_0218);
        set_pipe(5'd10, 32'hA0); set_lu(5'd3, 32'h33); tick();
        chk_port("cont_a", 5'd10, 32'hA0);
        set_pipe(5'd11, 32'hA1); set_lu(5'd4, 32'h44); tick();
        chk("cont_full", {31'd0, bus.lu_ready}, 32'd0);
        set_pipe(5'd12, 32'hA2); set_lu(5'd9, 32'h99); tick();
        chk("cont_c_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("cont_c_busy", bus.busy_o, 32'h0000_0218);
        set_pipe(5'd13, 32'hA3); tick();
        set_pipe(5'd14, 32'hA4); tick();
        chk("cont_stall", {31'd0, bus.stall_o}, 32'd1);
        chk_port("cont_e", 5'd14, 32'hA4);
        bus.pipe_valid = 1'b0; tick();
        chk_port("cont_x3", 5'd3, 32'h33);
        chk("cont_stall_off", {31'd0, bus.stall_o}, 32'd0);
        chk("cont_busy3", bus.busy_o, 32'h0000_0210);
        tick(); clr_all();
        chk_port("cont_x4", 5'd4, 32'h44);
        chk("cont_busy4", bus.busy_o, 32'h0000_0200);
        tick();
        chk_port("cont_x9", 5'd9, 32'h99);
        chk("cont_busy9", bus.busy_o, 32'd0);
        chk("cont_err", {31'd0, bus.err_o}, 32'd0);

        // rd = 0
        set_issue(5'd0); tick(); clr_all();
        chk("x0_issue_busy", bus.busy_o, 32'd0);
        set_pipe(5'd0, 32'h55); tick(); clr_all();
        chk("x0_pipe_wr", {31'd0, bus.write_reg}, 32'd0);
        set_lu(5'd0, 32'h77); tick(); clr_all();
        chk("x0_lu_wr", {31'd0, bus.write_reg}, 32'd0);
        chk("x0_lu_err", {31'd0, bus.err_o}, 32'd1);

        // Set/clear collision
        set_issue(5'd6); tick();
        set_lu(5'd6, 32'h66); tick(); clr_all();
        chk_port("coll", 5'd6, 32'h66);
        chk("coll_busy", bus.busy_o, 32'h0000_0040);
        set_lu(5'd6, 32'h67); tick(); clr_all();
        chk_port("coll2", 5'd6, 32'h67);
        chk("coll2_busy", bus.busy_o, 32'd0);

        // Async reset with two buffered entries
        set_issue(5'd3); tick();
        set_issue(5'd4); tick(); clr_all();
        set_pipe(5'd20, 32'hB0); set_lu(5'd3, 32'h33); set_issue(5'd12); tick(); clr_all();
        set_pipe(5'd21, 32'hB1); set_lu(5'd4, 32'h44); tick(); clr_all();
        chk("pre_rst_full", {31'd0, bus.lu_ready}, 32'd0);
        chk("pre_rst_busy", bus.busy_o, 32'h0000_1018);
        chk_port("pre_rst", 5'd21, 32'hB1);
        set_pipe(5'd22, 32'hB2);
        rst = 1'b0;
        #1;
        chk("arst_write_reg", {31'd0, bus.write_reg}, 32'd0);
        chk("arst_target", {27'd0, bus.target_reg}, 32'd0);
        chk("arst_data", bus.write_rd_data, 32'd0);
        chk("arst_busy", bus.busy_o, 32'd0);
        chk("arst_err", {31'd0, bus.err_o}, 32'd0);
        chk("arst_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
        clr_all();
        tick();
        rst = 1'b1;
        tick();
        chk("arst_no_stale", {31'd0, bus.write_reg}, 32'd0);
        tick();
        chk("arst_no_stale2", {31'd0, bus.write_reg}, 32'd0);

        // Pipeline result during stall -> sticky error
        set_issue(5'd3); tick();
        set_issue(5'd4); tick(); clr_all();
        set_pipe(5'd30, 32'hC0); set_lu(5'd3, 32'h33); tick(); clr_all();
        set_pipe(5'd31, 32'hC1); set_lu(5'd4, 32'h44); tick(); clr_all();
        set_pipe(5'd32, 32'hC2); tick();
        set_pipe(5'd33, 32'hC3); tick();
        set_pipe(5'd34, 32'hC4); tick();
        chk("viol_stall", {31'd0, bus.stall_o}, 32'd1);
        chk("viol_err_before", {31'd0, bus.err_o}, 32'd0);
        set_pipe(5'd35, 32'hC5); tick(); clr_all();
        chk_port("viol_x3", 5'd3, 32'h33);
        chk("viol_err", {31'd0, bus.err_o}, 32'd1);
        tick();
        chk_port("viol_x4", 5'd4, 32'h44);
        chk("viol_err_sticky", {31'd0, bus.err_o}, 32'd1);
        chk("viol_busy", bus.busy_o, 32'd0);
        tick();
        chk("viol_idle_wr", {31'd0, bus.write_reg}, 32'd0);
        chk("viol_err_sticky2", {31'd0, bus.err_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
